// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, issue FSM encodings and the request payload.
// Used by the issue controller, the multiply/divide unit and the decoder.
package md_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 3;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } md_req_t;

  // Ops that occupy the multiply/divide unit.
  function automatic logic is_md_arith(input logic [OPW-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // Any op that touches HI/LO state (arith or move-to).
  function automatic logic is_md_any(input logic [OPW-1:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Handshake between the issue controller (master) and the multiply/divide unit (slave).
interface md_issue_ctrl_if;
  import md_pkg::*;

  logic            md_start;
  logic [OPW-1:0]  md_op;
  logic [XLEN-1:0] md_A;
  logic [XLEN-1:0] md_B;
  logic            md_busy;
  logic [XLEN-1:0] md_HI;
  logic [XLEN-1:0] md_LO;

  modport master (
    output md_start, md_op, md_A, md_B,
    input  md_busy, md_HI, md_LO
  );

  modport slave (
    input  md_start, md_op, md_A, md_B,
    output md_busy, md_HI, md_LO
  );

endinterface

// File: rtl/md_issue_ctrl.sv
// Issues Execute-stage multiply/divide ops to the md unit, owns architectural HI/LO,
// and stalls Decode while an md op is in flight.
module md_issue_ctrl
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            E_valid,
  input  logic [OPW-1:0]  E_md_op,
  input  logic [XLEN-1:0] E_rs,
  input  logic [XLEN-1:0] E_rt,
  input  logic            D_uses_md,
  md_issue_ctrl_if.master md,
  output logic [XLEN-1:0] HI_out,
  output logic [XLEN-1:0] LO_out,
  output logic            stall,
  output logic            md_err
);

  logic [1:0]      state_q, state_d;
  logic            start_q, start_d;
  md_req_t         req_q, req_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            err_q, err_d;
  logic            issue_now;
  logic            md_any;

  assign issue_now = E_valid & is_md_arith(E_md_op);
  assign md_any    = E_valid & is_md_any(E_md_op);
  assign stall     = D_uses_md & (issue_now | (state_q != ST_IDLE));

  assign md.md_start = start_q;
  assign md.md_op    = req_q.op;
  assign md.md_A     = req_q.a;
  assign md.md_B     = req_q.b;
  assign HI_out      = hi_q;
  assign LO_out      = lo_q;
  assign md_err      = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      req_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      req_q   <= req_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    req_d   = req_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_now) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          req_d   = '{op: E_md_op, a: E_rs, b: E_rt};
        end else if (E_valid && (E_md_op == MD_MTHI)) begin
          hi_d = E_rs;
        end else if (E_valid && (E_md_op == MD_MTLO)) begin
          lo_d = E_rs;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (md_any) err_d = 1'b1;
      end
      ST_WAIT: begin
        if (md_any) err_d = 1'b1;
        // Busy is already high on the first WAIT cycle, so low here means done.
        if (!md.md_busy) begin
          state_d = ST_IDLE;
          hi_d    = md.md_HI;
          lo_d    = md.md_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
